sram_dpfifo_ctrl: RTL and testbench
===================================

Name: sram_dpfifo_ctrl

Overview:
Initiator-side controller that drives both ports of the 128x16 dual-port SRAM macro and turns the macro into a single-clock FIFO.
- Port A is write-only and fed by a valid/ready push interface.
- Port B is read-only and prefetches into a 2-entry output skid buffer, so the pop interface sustains one word per cycle despite the macro's 1-cycle read latency.
- Sits between streaming producers/consumers and the SRAM macro instance; the top level ties clk to both CPA and CPB.

Parameters:
ADDR_W, 7, SRAM address width
DATA_W, 16, word width
DEPTH, 128, SRAM words (2**ADDR_W)
CNT_W, 8, occupancy counter width (holds DEPTH+2)

Ports:
clk  in  1  system clock, rising edge; also drives CPA/CPB at top level
rst  in  1  asynchronous, active-high reset
in_valid  in  1  push request
in_ready  out  1  push accepted when in_valid&in_ready
in_data  in  DATA_W  push word
out_valid  out  1  pop word available
out_ready  in  1  consumer accepts when out_valid&out_ready
out_data  out  DATA_W  pop word
count  out  CNT_W  total words held (SRAM + in-flight + skid)
max_count  out  CNT_W  high watermark (see Optional Feature)
mem_aa  out  ADDR_W  port A address
mem_csba, mem_weba, mem_reba, mem_oeba  out  1 each  port A active-low strobes
mem_ia  out  DATA_W  port A write data
mem_ab  out  ADDR_W  port B address
mem_csbb, mem_webb, mem_rebb, mem_oebb  out  1 each  port B active-low strobes
mem_ob  in  DATA_W  port B read data

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - wr_ptr=rd_ptr=0, sram_used=0, count=0, max_count=0.
  - Skid buffer empty, in-flight flag clear, out_valid=0, out_data=0.
  - in_ready=0 while rst is high, then 1.
  - mem_csba=mem_csbb=1, mem_weba=mem_webb=1, mem_reba=mem_rebb=1, mem_oeba=mem_oebb=0.
  - mem_aa=mem_ab=0, mem_ia=0.
- Macro timing: an access is sampled at the clk edge with CSB=0. For a read (REB=0), mem_ob is valid in the following cycle. OEB is held at 0 permanently.
- All mem_* outputs are registered.
- Write:
  - in_ready = (sram_used < DEPTH), combinational from registered state.
  - On a push, the next cycle drives csba=0, weba=0, reba=1, aa=wr_ptr, ia=in_data; wr_ptr increments.
  - With no push, csba=1.
- Read (prefetch):
  - Issue when sram_used_committed > 0 AND (skid_cnt + inflight) < 2, unless the skid frees a slot this cycle.
  - Issue drives csbb=0, rebb=0, webb=1, ab=rd_ptr; rd_ptr increments and the in-flight flag is set.
  - In the next cycle, mem_ob is captured into the skid tail.
- Write-to-read hazard: reads use the committed count, which counts a word only after its write cycle. A read therefore never targets the address being written in the same cycle.
- Pointers wrap modulo DEPTH with no extra handling.
- Occupancy:
  - sram_used tracks push minus read-issue.
  - count increments on push and decrements on pop. Simultaneous push and pop leaves it unchanged.
  - Maximum count is DEPTH+2.
- Skid buffer: 2-entry FIFO; out_valid = skid not empty; out_data = head.
  - Pop and capture in the same cycle are legal.
  - A capture into a full skid is impossible by the issue rule (verify with an assertion).
- Latency: a word pushed into an empty FIFO appears on out_valid 3 cycles after its push edge (write, read issue, capture).
- Throughput: 1 push and 1 pop per cycle, sustained.
- Reset mid-operation: all contents are discarded, any in-flight read is dropped, and the SRAM array is not cleared.

Optional Feature:
SRAM_FIFO_WMARK_EN
- Defined: max_count is a register; when count > max_count, it loads count on the next edge. Cleared only by rst.
- Undefined: max_count is tied to 0 and no register is inferred.

Decomposition:
- Package sram_fifo_pkg holds:
  - ADDR_W, DATA_W, DEPTH, CNT_W, SKID_DEPTH=2.
  - A typedef for the SRAM port strobe bundle {csb, web, reb, oeb} with its idle constant {1,1,1,0}.
- Sub-module sram_fifo_skid: 2-entry valid/ready output buffer, exposing free-slot count.

Test Plan:
- Reset release, then push 0x1234 at cycle 0 -> mem_aa=0/mem_weba=0 at cycle 1; rebb=0/ab=0 at cycle 2; out_valid=1 with out_data=0x1234 at cycle 3; count=1.
- Push 130 words 0x0000..0x0081 with out_ready=0 -> in_ready drops after word 130, count=130. Then pop all -> data in order, count returns to 0.
- Continuous push and pop with out_ready=1 for 500 words -> one word per cycle after 3-cycle fill; pointers wrap past 127; data ordered; count steady.
- Random out_ready backpressure (50%) with random in_valid -> scoreboard match, no skid overflow assertion fires, mem_csbb never 0 with rd_ptr equal to the same-cycle write address.
- Assert rst with 40 words stored and a read in flight -> all outputs at reset values asynchronously; after release out_valid stays 0 until a new push.
- With SRAM_FIFO_WMARK_EN: fill to 57, drain to 3, refill to 20 -> max_count=57. Without the macro -> max_count=0 throughout.

Source files
------------

// File: rtl/sram_dpfifo_ctrl_pkg.sv
// Shared sizes and SRAM strobe encodings for the dual-port SRAM FIFO controller.
package sram_fifo_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 16;
    localparam int DEPTH      = 2 ** ADDR_W;
    localparam int CNT_W      = 8;
    localparam int SKID_DEPTH = 2;

    // Active-low macro strobes, MSB first to match the {csb, web, reb, oeb} pin order.
    typedef struct packed {
        logic csb;
        logic web;
        logic reb;
        logic oeb;
    } sram_strb_t;

    localparam sram_strb_t STRB_IDLE  = '{csb: 1'b1, web: 1'b1, reb: 1'b1, oeb: 1'b0};
    localparam sram_strb_t STRB_WRITE = '{csb: 1'b0, web: 1'b0, reb: 1'b1, oeb: 1'b0};
    localparam sram_strb_t STRB_READ  = '{csb: 1'b0, web: 1'b1, reb: 1'b0, oeb: 1'b0};

endpackage

// File: rtl/sram_dpfifo_ctrl_if.sv
// Push/pop stream handshake of the SRAM FIFO; slave is the FIFO, master the environment.
interface sram_dpfifo_ctrl_if;
    import sram_fifo_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/sram_dpfifo_ctrl_skid.sv
// Two-entry output skid buffer; reports free slots so the controller can prefetch safely.
module sram_fifo_skid
    import sram_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        free
);
    logic [DATA_W-1:0] entry [SKID_DEPTH];
    logic              wp, rp;
    logic [1:0]        cnt;
    logic              rd_en;

    assign rd_en = rd_valid & rd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these two entries are reset so out_data reads 0 after reset;
            // the SRAM array behind them is deliberately never cleared.
            for (int i = 0; i < SKID_DEPTH; i++) entry[i] <= '0;
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= '0;
        end else begin
            // NOTE: non-blocking updates let cnt, pointers and entries all see pre-edge values.
            if (wr_en) begin
                entry[wp] <= wr_data;
                wp        <= ~wp;
            end
            if (rd_en) rp <= ~rp;
            cnt <= cnt + 2'(wr_en) - 2'(rd_en);
        end
    end

    assign rd_valid = (cnt != 2'd0);
    assign rd_data  = entry[rp];
    assign free     = 2'(SKID_DEPTH) - cnt;

    skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && cnt == 2'(SKID_DEPTH) && !rd_en));

endmodule

// File: rtl/sram_dpfifo_ctrl.sv
// Single-clock FIFO over a 128x16 dual-port SRAM: port A writes pushes, port B prefetches.
// Optional high-watermark register enabled by `define SRAM_FIFO_WMARK_EN.
module sram_dpfifo_ctrl
    import sram_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    sram_dpfifo_ctrl_if.slave fifo,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  max_count,
    output logic [ADDR_W-1:0] mem_aa,
    output logic              mem_csba,
    output logic              mem_weba,
    output logic              mem_reba,
    output logic              mem_oeba,
    output logic [DATA_W-1:0] mem_ia,
    output logic [ADDR_W-1:0] mem_ab,
    output logic              mem_csbb,
    output logic              mem_webb,
    output logic              mem_rebb,
    output logic              mem_oebb,
    input  logic [DATA_W-1:0] mem_ob
);
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  sram_used;
    sram_strb_t        strb_a, strb_b;
    logic              push, pop, issue, inflight;
    logic [1:0]        skid_free;

    // sram_used only counts a word after its push edge, so a read never races its write.
    assign fifo.in_ready = !rst && (sram_used < CNT_W'(DEPTH));
    assign push          = fifo.in_valid & fifo.in_ready;
    assign pop           = fifo.out_valid & fifo.out_ready;
    assign inflight      = ~strb_b.csb;
    assign issue         = (sram_used != '0) &&
                           (({1'b0, skid_free} + {2'b00, pop}) > {2'b00, inflight});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            sram_used <= '0;
            count     <= '0;
            strb_a    <= STRB_IDLE;
            strb_b    <= STRB_IDLE;
            mem_aa    <= '0;
            mem_ia    <= '0;
            mem_ab    <= '0;
        end else begin
            strb_a <= push  ? STRB_WRITE : STRB_IDLE;
            strb_b <= issue ? STRB_READ  : STRB_IDLE;
            if (push) begin
                mem_aa <= wr_ptr;
                mem_ia <= fifo.in_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                mem_ab <= rd_ptr;
                rd_ptr <= rd_ptr + 1'b1;
            end
            sram_used <= sram_used + CNT_W'(push) - CNT_W'(issue);
            count     <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign {mem_csba, mem_weba, mem_reba, mem_oeba} = strb_a;
    assign {mem_csbb, mem_webb, mem_rebb, mem_oebb} = strb_b;

    sram_fifo_skid u_skid (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (inflight),
        .wr_data  (mem_ob),
        .rd_valid (fifo.out_valid),
        .rd_ready (fifo.out_ready),
        .rd_data  (fifo.out_data),
        .free     (skid_free)
    );

`ifdef SRAM_FIFO_WMARK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    max_count <= '0;
        else if (count > max_count) max_count <= count;
    end
`else
    assign max_count = '0;
`endif

endmodule

// File: tb/tb_sram_dpfifo_ctrl.sv
// Directed bench for sram_dpfifo_ctrl with a behavioural SRAM macro and a word scoreboard.
module tb_sram_dpfifo_ctrl;
    import sram_fifo_pkg::*;

`ifdef SRAM_FIFO_WMARK_EN
    localparam int WM_FULL = 130;
    localparam int WM_57   = 57;
`else
    localparam int WM_FULL = 0;
    localparam int WM_57   = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [CNT_W-1:0]  count, max_count;
    logic [ADDR_W-1:0] mem_aa, mem_ab;
    logic              mem_csba, mem_weba, mem_reba, mem_oeba;
    logic              mem_csbb, mem_webb, mem_rebb, mem_oebb;
    logic [DATA_W-1:0] mem_ia, mem_ob;
    logic [DATA_W-1:0] sram [DEPTH];

    int total = 0, bad = 0, n_push = 0, n_pop = 0, hazard = 0;
    logic [DATA_W-1:0] sb [$];

    sram_dpfifo_ctrl_if bus ();

    sram_dpfifo_ctrl dut (
        .clk(clk), .rst(rst), .fifo(bus), .count(count), .max_count(max_count),
        .mem_aa(mem_aa), .mem_csba(mem_csba), .mem_weba(mem_weba), .mem_reba(mem_reba),
        .mem_oeba(mem_oeba), .mem_ia(mem_ia), .mem_ab(mem_ab), .mem_csbb(mem_csbb),
        .mem_webb(mem_webb), .mem_rebb(mem_rebb), .mem_oebb(mem_oebb), .mem_ob(mem_ob)
    );

    always #5 clk = ~clk;

    // Macro model: write lands at the edge closing the strobe cycle; read data for the
    // presented address is returned within its strobe cycle and a marker otherwise.
    always @(posedge clk) if (!mem_csba && !mem_weba) sram[mem_aa] <= mem_ia;
    assign mem_ob = (!mem_csbb && !mem_rebb) ? sram[mem_ab] : 16'h5a5a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard the pop about to happen, then advance to edge+1.
    task automatic step();
        logic pf, qf;
        logic [DATA_W-1:0] d, e;
        pf = bus.in_valid && bus.in_ready;
        qf = bus.out_valid && bus.out_ready;
        d  = bus.in_data;
        if (!mem_csba && !mem_csbb && mem_aa == mem_ab) hazard++;
        if (qf) begin
            check("pop_queue_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pop_data", 32'(bus.out_data), 32'(e));
            end
            n_pop++;
        end
        @(posedge clk);
        #1;
        if (pf) begin
            sb.push_back(d);
            n_push++;
        end
    endtask

    task automatic settle(input int k);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (k) step();
    endtask

    task automatic push_n(input int n, input logic [DATA_W-1:0] base);
        int start, guard;
        start = n_push;
        guard = 0;
        bus.in_valid = 1'b1;
        while (n_push - start < n && guard < n + 50) begin
            bus.in_data = base + DATA_W'(n_push - start);
            step();
            guard++;
        end
        bus.in_valid = 1'b0;
        check("push_n_accepted", n_push - start, n);
    endtask

    task automatic pop_n(input int n);
        int start, guard;
        start = n_pop;
        guard = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (n_pop - start < n && guard < n + 50) begin
            step();
            guard++;
        end
        bus.out_ready = 1'b0;
        check("pop_n_popped", n_pop - start, n);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_out_data"},  32'(bus.out_data),  0);
        check({tag, "_count"},     32'(count),         0);
        check({tag, "_max_count"}, 32'(max_count),     0);
        check({tag, "_strb_a"},    32'({mem_csba, mem_weba, mem_reba, mem_oeba}), 32'hE);
        check({tag, "_strb_b"},    32'({mem_csbb, mem_webb, mem_rebb, mem_oebb}), 32'hE);
        check({tag, "_addr"},      32'({mem_aa, mem_ab}), 0);
        check({tag, "_mem_ia"},    32'(mem_ia),        0);
    endtask

    initial begin
        int p0, pop_a, pop_b;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #3;
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", 32'(bus.in_ready), 1);

        // Single-word latency: write strobe, read strobe, then out_valid.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        step();
        bus.in_valid = 1'b0;
        check("c1_write_strobe", 32'({mem_csba, mem_weba, mem_reba}), 32'h1);
        check("c1_mem_aa",  32'(mem_aa), 0);
        check("c1_mem_ia",  32'(mem_ia), 32'h1234);
        check("c1_count",   32'(count),  1);
        step();
        check("c2_read_strobe", 32'({mem_csbb, mem_webb, mem_rebb}), 32'h2);
        check("c2_mem_ab",  32'(mem_ab), 0);
        check("c2_no_valid", 32'(bus.out_valid), 0);
        step();
        check("c3_out_valid", 32'(bus.out_valid), 1);
        check("c3_out_data",  32'(bus.out_data),  32'h1234);
        check("c3_count",     32'(count),         1);
        pop_n(1);
        check("c4_count", 32'(count), 0);

        // Fill to DEPTH+2 with no consumer, confirm backpressure, then drain in order.
        push_n(130, 16'h0000);
        settle(3);
        check("full_in_ready", 32'(bus.in_ready), 0);
        check("full_count",    32'(count),        130);
        check("full_max",      32'(max_count),    WM_FULL);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hdead;
        repeat (3) step();
        bus.in_valid = 1'b0;
        check("full_refused", 32'(count), 130);
        pop_n(130);
        settle(2);
        check("drained_count", 32'(count), 0);
        check("drained_valid", 32'(bus.out_valid), 0);

        // Streaming: one push and one pop per cycle, pointers wrap several times.
        p0 = n_push;
        pop_a = 0;
        pop_b = 0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (cyc == 100) pop_a = n_pop;
            if (cyc == 400) pop_b = n_pop;
            if (cyc == 250) check("stream_count", 32'(count), 3);
            bus.in_data = 16'h1000 + DATA_W'(n_push - p0);
            step();
        end
        check("stream_pushes", n_push - p0, 500);
        check("stream_rate",   pop_b - pop_a, 300);
        pop_n(sb.size());
        check("stream_drained", 32'(count), 0);

        // Random producer and 50% consumer backpressure.
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = DATA_W'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        bus.in_valid = 1'b0;
        check("rand_count", 32'(count), sb.size());
        pop_n(sb.size());
        check("rand_drained", 32'(count), 0);
        check("rw_hazard", hazard, 0);

        // Reset with 40 words held and a read strobe outstanding.
        push_n(40, 16'h0200);
        settle(3);
        check("pre_rst_count", 32'(count), 40);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("pre_rst_inflight", 32'(mem_csbb), 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        settle(4);
        check("post_rst_valid", 32'(bus.out_valid), 0);
        check("post_rst_count", 32'(count), 0);
        push_n(1, 16'hbeef);
        settle(3);
        check("post_rst_word_valid", 32'(bus.out_valid), 1);
        check("post_rst_word_data",  32'(bus.out_data),  32'hbeef);
        pop_n(1);

        // Watermark: fill to 57, drain to 3, refill to 20.
        push_n(57, 16'h0300);
        settle(3);
        check("wm_fill", 32'(count), 57);
        pop_n(54);
        settle(2);
        check("wm_drain", 32'(count), 3);
        push_n(17, 16'h0400);
        settle(3);
        check("wm_refill", 32'(count), 20);
        check("wm_max", 32'(max_count), WM_57);
        pop_n(20);
        check("wm_empty", 32'(count), 0);
        check("final_hazard", hazard, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
